// File: rtl/mole_hit_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : whack_pkg
// Description : Shared constants and BCD score helpers for the mole hit
//               detector (mole count, score ceiling, saturating increment,
//               floored decrement).
// Revision    : 1.0 - initial release
// ============================================================================
package whack_pkg;

    localparam int          NUM_MOLES = 4;
    localparam logic [7:0]  BCD_MAX   = 8'h99;

    // Two-digit BCD increment that sticks at 99 instead of wrapping.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v >= BCD_MAX) begin
            r = BCD_MAX;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD decrement that sticks at 00 instead of wrapping.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage : whack_pkg
`default_nettype wire

// File: rtl/mole_hit_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : mole_hit_detector_if
// Description : Bundle between the game side and the mole hit detector.
//               master : drives raw buttons, mole pattern, enable, score clear
//                        and observes the detector outputs.
//               slave  : the detector itself.
//   button    [3:0] raw push buttons (1 = pressed)
//   color     [3:0] current mole pattern (1 = mole up)
//   enable          game active
//   score_clr       synchronous score clear
//   btn_level [3:0] debounced button levels
//   hit_pulse       one-cycle: at least one hit
//   miss_pulse      one-cycle: at least one miss
//   whack_clr [3:0] one-cycle per-mole drop strobe
//   score_bcd [7:0] two-digit BCD hit score
// Revision    : 1.0 - initial release
// ============================================================================
interface mole_hit_detector_if;
    import whack_pkg::*;

    logic [NUM_MOLES-1:0] button;
    logic [NUM_MOLES-1:0] color;
    logic                 enable;
    logic                 score_clr;
    logic [NUM_MOLES-1:0] btn_level;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic [NUM_MOLES-1:0] whack_clr;
    logic [7:0]           score_bcd;

    modport master (
        output button, color, enable, score_clr,
        input  btn_level, hit_pulse, miss_pulse, whack_clr, score_bcd
    );

    modport slave (
        input  button, color, enable, score_clr,
        output btn_level, hit_pulse, miss_pulse, whack_clr, score_bcd
    );

endinterface : mole_hit_detector_if
`default_nettype wire

// File: rtl/mole_hit_detector_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : One button channel: 2-flop synchroniser followed by a
//               stability counter. The debounced level only follows the
//               synchronised input after it has differed for DB_CYCLES
//               consecutive cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   button     : raw asynchronous button input
//   level      : debounced level
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int DB_CNT_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic level
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic                sync1_q, sync1_d;
    logic                bs_q, bs_d;
    logic                stable_q, stable_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = button;
        bs_d     = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (bs_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Differed for DB_CYCLES consecutive evaluations: accept.
            stable_d = bs_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            bs_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            bs_q     <= bs_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;

endmodule : button_debounce
`default_nettype wire

// File: rtl/mole_hit_detector.sv
`default_nettype none
// ============================================================================
// Module      : mole_hit_detector
// Description : Debounces the four player buttons, turns debounced rising
//               edges into hit/miss classifications against the current
//               mole pattern, and keeps a saturating two-digit BCD score.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : mole_hit_detector_if.slave (buttons, pattern, enable,
//            score clear in; levels, pulses, strobes, score out)
// Optional : define MISS_PENALTY_EN to subtract one point per miss cycle
//            (floored at 00; a cycle with both hit and miss nets zero).
// Revision    : 1.0 - initial release
// ============================================================================
module mole_hit_detector
    import whack_pkg::*;
#(
    parameter int DB_CYCLES = 50000,
    parameter int DB_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mole_hit_detector_if.slave    bus
);

    logic [NUM_MOLES-1:0] w_level;

    logic [NUM_MOLES-1:0] stable_dly_q, stable_dly_d;
    logic [NUM_MOLES-1:0] press_q, press_d;
    logic [NUM_MOLES-1:0] whack_q, whack_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [7:0]           score_q, score_d;

    for (genvar gi = 0; gi < NUM_MOLES; gi++) begin : g_chan
        button_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .DB_CNT_W  (DB_CNT_W)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .button (bus.button[gi]),
            .level  (w_level[gi])
        );
    end

    always_comb begin
        stable_dly_d = w_level;
        // Rising edges only; releases never generate an event.
        press_d      = w_level & ~stable_dly_q;
        whack_d      = press_q & {NUM_MOLES{bus.enable}} &  bus.color;
        hit_d        = |whack_d;
        miss_d       = |(press_q & {NUM_MOLES{bus.enable}} & ~bus.color);

        // Score follows the registered pulses; clear wins over everything.
        score_d = score_q;
        if (bus.score_clr) begin
            score_d = 8'h00;
        end else begin
`ifdef MISS_PENALTY_EN
            if (hit_q && !miss_q) begin
                score_d = bcd_inc(score_q);
            end else if (miss_q && !hit_q) begin
                score_d = bcd_dec(score_q);
            end
`else
            if (hit_q) begin
                score_d = bcd_inc(score_q);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_dly_q <= '0;
            press_q      <= '0;
            whack_q      <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            score_q      <= 8'h00;
        end else begin
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
            whack_q      <= whack_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            score_q      <= score_d;
        end
    end

    assign bus.btn_level  = w_level;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.whack_clr  = whack_q;
    assign bus.score_bcd  = score_q;

endmodule : mole_hit_detector
`default_nettype wire

// File: doc/mole_hit_detector.md
Name: mole_hit_detector

Overview:
- Input-side counterpart to the game FSM.
- Takes the four raw player buttons and the current mole pattern, then synchronises and debounces each button.
- Classifies each press as a hit (mole lit) or a miss (mole dark).
- Returns one-cycle hit/miss events, per-mole clear strobes, and a saturating 2-digit BCD hit score for the score display.

Parameters:
- DB_CYCLES, 50000, consecutive stable cycles required before a button level change is accepted (must be ≥1).
- DB_CNT_W, 16, width of each debounce counter; must satisfy 2^DB_CNT_W > DB_CYCLES.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- button, input, 4, raw asynchronous push buttons; 1 = pressed.
- color, input, 4, current mole pattern from the game FSM; 1 = mole up.
- enable, input, 1, game active; presses are classified only while high.
- score_clr, input, 1, synchronous clear of the score to 00.
- btn_level, output, 4, debounced button levels.
- hit_pulse, output, 1, one-cycle pulse: at least one hit this cycle.
- miss_pulse, output, 1, one-cycle pulse: at least one miss this cycle.
- whack_clr, output, 4, one-cycle per-mole strobe to drop each hit mole.
- score_bcd, output, 8, hit score; [7:4] = tens, [3:0] = units, BCD.

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, debounce counters, stable levels, pulses and score go to 0. Outputs read btn_level = 0, hit_pulse = 0, miss_pulse = 0, whack_clr = 0, score_bcd = 8'h00.
- Per channel, synchronisation: a 2-flop synchroniser produces bs.
- Per channel, debounce:
  - If bs == stable, the counter resets to 0.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1 while still differing, stable <= bs and the counter resets to 0.
  - A glitch shorter than DB_CYCLES cycles never changes stable.
- Press event: registered rise detect, press[i] = stable[i] & ~stable_d[i].
  - Release events are ignored.
- Classification (registered):
  - On press[i] with enable = 1: hit if color[i] = 1, else miss.
  - whack_clr[i] = press[i] & enable & color[i].
  - hit_pulse = |whack_clr.
  - miss_pulse = |(press & enable & ~color).
- Latency: a clean raw 0->1 edge settled before edge k gives hit_pulse/miss_pulse/whack_clr high for exactly one cycle, starting at edge k+DB_CYCLES+3.
- Score:
  - On hit_pulse, score increments by 1 in BCD; units 9 -> 0 with a tens carry.
  - The score saturates at 99.
  - Multiple simultaneous hits in one cycle count as +1.
- Simultaneous events:
  - A cycle with both hits and misses asserts both pulses.
  - score_clr has priority over increment and penalty in the same cycle.
- enable low: presses are silently discarded, and debouncing continues so levels stay valid. Holding a button across enable rising does not produce a press.
- Reset asserted mid-debounce or mid-pulse: everything clears immediately. After release, a held button is seen as a new press after DB_CYCLES+3 cycles.

Optional Feature:
- Macro MISS_PENALTY_EN.
- Defined: when miss_pulse is registered, the score decrements by 1 in BCD (tens borrow), with a floor at 00.
  - Hit and miss in the same cycle net to no change.
- Undefined: misses are only reported on miss_pulse; the score never decrements.

Decomposition:
- Package whack_pkg:
  - NUM_MOLES = 4.
  - BCD_MAX = 8'h99.
  - Function bcd_inc (saturating).
  - Function bcd_dec (floored).
- Sub-module button_debounce, one channel: synchroniser, counter and stable level. Instantiated NUM_MOLES times via generate.

Test Plan (DB_CYCLES = 4):
- Reset, then release: all outputs 0 and score_bcd = 00. Assert rst_n low mid-count: outputs clear within the same cycle, with no clock needed.
- button[2] held high, color = 4'b0100, enable = 1: exactly one hit_pulse and one whack_clr = 4'b0100, 7 cycles after the edge; score 00 -> 01.
- button[0] glitch of 3 cycles: btn_level[0] never rises and no pulses. A 10-cycle press gives one event; on release, no event.
- button[1] pressed with color = 4'b0000: miss_pulse is 1 cycle and the score is unchanged. With MISS_PENALTY_EN and score 10: score -> 09. With MISS_PENALTY_EN and score 00: score stays 00.
- Preload 98 via hits, then 3 more hits: 99, 99, 99, with no wrap. Assert score_clr together with a hit: result is 00.
- Press buttons 0 and 3 together, color = 4'b1000, enable = 1: whack_clr = 4'b1000, hit_pulse and miss_pulse both asserted, score +1. Repeat with enable = 0: no outputs.
